// File: rtl/axi4_lite_regfile_slave.sv
// rtl/axi4_lite_regfile_slave.sv - AXI4-Lite responder exposing a bank of 32-bit registers
//
// Purpose: independent AW/W capture, byte-strobed register writes with a
// single outstanding B response, and single-beat reads with one-cycle latency.
// Register 0 is a read-only ID constant; invalid or read-only accesses get SLVERR.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   awaddr/awvalid/awready              write address channel
//   wdata/wstrb/wvalid/wready           write data channel
//   bresp/bvalid/bready                 write response channel
//   araddr/arvalid/arready              read address channel
//   rdata/rresp/rvalid/rready           read data channel
module axi4_lite_regfile_slave #(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA4100001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned IDX_W      = $clog2(NUM_REGS);
  localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
  endfunction

  logic              aw_full_q, aw_full_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       regs_q [NUM_REGS];

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              wr_go, wr_ok;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  // Ready outputs depend on registered flags only.
  assign awready = !aw_full_q;
  assign wready  = !w_full_q;
  assign arready = !rvalid_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid_q && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid_q && rready;

  assign wr_idx = awaddr_q[2 +: IDX_W];
  assign rd_idx = araddr[2 +: IDX_W];

  // Flags stay set until the B handshake, so a write commits exactly once.
  assign wr_go = aw_full_q && w_full_q && !bvalid_q;
  assign wr_ok = addr_ok(awaddr_q) && (wr_idx != '0);

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (wr_go) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end

    // arready is !rvalid, so AR and R handshakes never share a cycle.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (!addr_ok(araddr)) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (rd_idx == '0) begin
        rdata_d = ID_VALUE;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = regs_q[rd_idx];
        rresp_d = RESP_OKAY;
      end
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Register bank; entry 0 is never written because reads of index 0 return ID_VALUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_go && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          regs_q[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// tb/tb_axi4_lite_regfile_slave.sv - self-checking bench for axi4_lite_regfile_slave
module tb_axi4_lite_regfile_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int errors = 0;

  axi4_lite_regfile_slave #(.NUM_REGS(16), .ID_VALUE(32'hA4100001)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write with AW and W presented together; checks one-cycle B latency.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input string name);
    int n;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " b_latency"}, 32'(n), 32'd1);
    chk({name, " bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk({name, " bvalid_clr"}, {31'd0, bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string name);
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk({name, " rvalid"}, {31'd0, rvalid}, 32'd1);
    chk({name, " rdata"}, rdata, exp_data);
    chk({name, " rresp"}, {30'd0, rresp}, {30'd0, exp_resp});
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk({name, " rvalid_clr"}, {31'd0, rvalid}, 32'd0);
  endtask

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // {is_write, addr, write data or expected read data, strobe, expected response}
    vecs[0]  = '{1'b0, 32'h00, 32'hA4100001, 4'h0, 2'b00};
    vecs[1]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00};
    vecs[2]  = '{1'b0, 32'h04, 32'hDEADBEEF, 4'h0, 2'b00};
    vecs[3]  = '{1'b1, 32'h04, 32'h11223344, 4'h5, 2'b00};
    vecs[4]  = '{1'b0, 32'h04, 32'hDE22BE44, 4'h0, 2'b00};
    vecs[5]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 2'b10};
    vecs[6]  = '{1'b0, 32'h00, 32'hA4100001, 4'h0, 2'b00};
    vecs[7]  = '{1'b1, 32'h40, 32'h55555555, 4'hF, 2'b10};
    vecs[8]  = '{1'b0, 32'h40, 32'h00000000, 4'h0, 2'b10};
    vecs[9]  = '{1'b1, 32'h06, 32'h77777777, 4'hF, 2'b10};
    vecs[10] = '{1'b0, 32'h06, 32'h00000000, 4'h0, 2'b10};
    vecs[11] = '{1'b0, 32'h04, 32'hDE22BE44, 4'h0, 2'b00};
    vecs[12] = '{1'b1, 32'h04, 32'h00000000, 4'h0, 2'b00};
    vecs[13] = '{1'b0, 32'h04, 32'hDE22BE44, 4'h0, 2'b00};
    vecs[14] = '{1'b1, 32'h3C, 32'hCAFEF00D, 4'hE, 2'b00};
    vecs[15] = '{1'b0, 32'h3C, 32'hCAFEF000, 4'h0, 2'b00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst awready", {31'd0, awready}, 32'd1);
    chk("rst wready", {31'd0, wready}, 32'd1);
    chk("rst arready", {31'd0, arready}, 32'd1);
    chk("rst bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst resp", {28'd0, bresp, rresp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_write)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, $sformatf("vec%0d wr", i));
      else
        do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, $sformatf("vec%0d rd", i));
    end

    // W three cycles ahead of AW, then B held off for four cycles.
    @(negedge clk);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("wfirst wready", {31'd0, wready}, 32'd0);
    chk("wfirst awready", {31'd0, awready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("wfirst no_b", {31'd0, bvalid}, 32'd0);
    @(negedge clk);
    awaddr = 32'h08; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("wfirst b_early", {31'd0, bvalid}, 32'd0);
    @(posedge clk); #1;
    chk("wfirst bvalid", {31'd0, bvalid}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d bvalid", c), {31'd0, bvalid}, 32'd1);
      chk($sformatf("hold%0d bresp", c), {30'd0, bresp}, 32'd0);
      chk($sformatf("hold%0d readies", c), {30'd0, awready, wready}, 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("wfirst bvalid_clr", {31'd0, bvalid}, 32'd0);
    chk("wfirst readies", {30'd0, awready, wready}, 32'd3);
    do_read(32'h08, 32'h12345678, 2'b00, "wfirst rd");

    // Read of 0xC sampled on the same edge the write to 0xC commits.
    @(negedge clk);
    awaddr = 32'h0C; awvalid = 1'b1;
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    araddr = 32'h0C; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("coll bvalid", {31'd0, bvalid}, 32'd1);
    chk("coll rvalid", {31'd0, rvalid}, 32'd1);
    chk("coll rdata_old", rdata, 32'd0);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    do_read(32'h0C, 32'hA5A5A5A5, 2'b00, "coll rd2");

    // Reset with AW captured (W pending) and a read response stalled.
    @(negedge clk);
    awaddr = 32'h04; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("mid awready", {31'd0, awready}, 32'd0);
    @(negedge clk);
    araddr = 32'h04; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("mid rvalid", {31'd0, rvalid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valids", {30'd0, bvalid, rvalid}, 32'd0);
    chk("arst readies", {29'd0, awready, wready, arready}, 32'd7);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post readies", {29'd0, awready, wready, arready}, 32'd7);
    chk("post bvalid", {31'd0, bvalid}, 32'd0);
    do_read(32'h04, 32'h00000000, 2'b00, "post rd4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
